// File: rtl/pdcch_fifo_reader.sv
// Reads a fixed-length frame from an upstream FIFO with one-cycle read latency and
// replays it as an AXI-Stream frame through a 2-entry skid buffer.
module pdcch_fifo_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_valid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  done,
  output logic                  proto_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = 1;

  state_t                r_state;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_issued;
  logic [LEN_WIDTH-1:0]  r_sent;
  logic [DATA_WIDTH-1:0] r_buf [2];
  logic                  r_head;
  logic [1:0]            r_count;
  logic                  r_inflight;
  logic                  r_done;
  logic                  r_proto_err;

  logic       w_pop;
  logic       w_push;
  logic       w_tail;
  logic [2:0] w_occ;
  logic       w_rd_en;
  logic       w_last;

  assign m_axis_tvalid = (r_count != 2'd0);
  assign m_axis_tdata  = r_buf[r_head];
  assign w_last        = (r_sent == r_len - LEN_ONE);
  assign m_axis_tlast  = m_axis_tvalid & w_last;
  assign w_pop         = m_axis_tvalid & m_axis_tready;
  assign w_push        = fifo_valid & r_inflight;
  assign w_tail        = r_head ^ r_count[0];

  // Occupancy once everything already requested has landed, net of this cycle's pop.
  assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_en = (r_state == S_RUN) & ~fifo_empty & (r_issued < r_len) & (w_occ < 3'd2);

  assign fifo_rd_en = w_rd_en;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign proto_err  = r_proto_err;

  always_ff @(posedge aclk) begin
    if (!reset) begin
      r_inflight  <= 1'b0;
      r_head      <= 1'b0;
      r_count     <= 2'd0;
      r_proto_err <= 1'b0;
      for (int i = 0; i < 2; i++) r_buf[i] <= '0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_push) r_buf[w_tail] <= fifo_data;
      if (w_pop) r_head <= ~r_head;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      // Unsolicited data is dropped; the flag stays up until reset.
      if (fifo_valid && !r_inflight) r_proto_err <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_len    <= '0;
      r_issued <= '0;
      r_sent   <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_pop) r_sent <= r_sent + LEN_ONE;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (frame_len != '0) begin
              r_len    <= frame_len;
              r_issued <= '0;
              r_sent   <= '0;
              r_state  <= S_RUN;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_rd_en) begin
            r_issued <= r_issued + LEN_ONE;
            if (r_issued == r_len - LEN_ONE) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_pop && w_last) r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pdcch_fifo_reader.md
PDCCH_FIFO_READER -- requirements
Module: pdcch_fifo_reader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the FIFO/stream data width.
REQ-002 The block SHALL have parameter LEN_WIDTH, default 16, giving the frame-length width.
REQ-003 The block SHALL have port aclk, input, 1, clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, reset; synchronous, active-low.
REQ-005 The block SHALL have port start, input, 1, frame request pulse, sampled in IDLE only.
REQ-006 The block SHALL have port frame_len, input, LEN_WIDTH, beats per frame, latched on accepted start.
REQ-007 The block SHALL have port fifo_empty, input, 1, upstream FIFO empty flag.
REQ-008 The block SHALL have port fifo_rd_en, output, 1, upstream FIFO read strobe.
REQ-009 The block SHALL have port fifo_data, input, DATA_WIDTH, FIFO read data, valid with fifo_valid.
REQ-010 The block SHALL have port fifo_valid, input, 1, FIFO read data valid, exactly one cycle after fifo_rd_en.
REQ-011 The block SHALL have ports m_axis_tdata (output, DATA_WIDTH), m_axis_tvalid (output, 1), m_axis_tlast (output, 1) and m_axis_tready (input, 1): the AXI-Stream master.
REQ-012 The block SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-013 The block SHALL have port done, output, 1, one-cycle pulse at frame completion.
REQ-014 The block SHALL have port proto_err, output, 1, sticky: fifo_valid was seen with no read outstanding.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-016 In IDLE, start=1 with frame_len!=0 SHALL latch frame_len, clear issued_cnt/sent_cnt, and move to RUN next cycle.
REQ-017 In IDLE, start=1 with frame_len==0 SHALL pulse done next cycle and stay in IDLE, with no read issued.
REQ-018 The block SHALL hold a 2-entry output buffer and a 1-bit inflight flag, where inflight is fifo_rd_en registered.
REQ-019 fifo_rd_en SHALL be asserted only when state==RUN, !fifo_empty, issued_cnt<len, and (count+inflight-pop)<2, where pop = m_axis_tvalid & m_axis_tready.
REQ-020 Each fifo_rd_en SHALL increment issued_cnt; when issued_cnt reaches len, the FSM SHALL move RUN->DRAIN.
REQ-021 fifo_valid=1 SHALL write fifo_data into the buffer tail; a simultaneous push and pop SHALL keep the count unchanged.
REQ-022 m_axis_tvalid SHALL be (count!=0) and m_axis_tdata SHALL be the buffer head, registered; latency from fifo_rd_en to m_axis_tvalid SHALL be 2 cycles.
REQ-023 m_axis_tdata, m_axis_tvalid and m_axis_tlast SHALL hold stable while tvalid=1 and tready=0.
REQ-024 m_axis_tlast SHALL be 1 exactly on the beat with sent_cnt==len-1; sent_cnt SHALL increment on each pop.
REQ-025 In DRAIN, the pop of the tlast beat SHALL move the FSM to DONE; DONE SHALL assert done for one cycle and then go to IDLE.
REQ-026 Sustained throughput SHALL be 1 beat/cycle when the FIFO is non-empty and tready=1.
REQ-027 fifo_empty going high mid-frame SHALL stall reads without error, and reads SHALL resume when it falls.
REQ-028 fifo_valid with inflight=0 SHALL be discarded and SHALL set proto_err until reset.
REQ-029 start while busy SHALL be ignored.
REQ-030 Counters SHALL be LEN_WIDTH bits; a len of 2^LEN_WIDTH-1 SHALL complete without wrap.

Reset
REQ-031 While reset=0 at a rising edge, the block SHALL set: state IDLE, buffer count 0, inflight 0, counters 0, fifo_rd_en 0, m_axis_tvalid 0, m_axis_tlast 0, m_axis_tdata 0, busy 0, done 0, proto_err 0.
REQ-032 Reset mid-frame SHALL abort the frame; fifo_valid arriving in the first cycle after reset release SHALL be discarded and SHALL set proto_err.

Verification
REQ-033 The bench SHALL check: frame_len=4, FIFO holds 0x11..0x14, tready=1 -> rd_en cycles 1-4, tvalid cycles 3-6, tlast with 0x14, done at cycle 8.
REQ-034 The bench SHALL check: frame_len=8, tready toggling 1/0 -> all 8 beats in order, data held during stalls, buffer never over 2, no lost beat.
REQ-035 The bench SHALL check: fifo_empty=1 for 5 cycles mid-frame -> rd_en low, tvalid drops after buffer drains, frame resumes, done pulses once.
REQ-036 The bench SHALL check: start with frame_len=0 -> done pulse next cycle, rd_en never asserted, busy stays 0.
REQ-037 The bench SHALL check: reset=0 during beat 3 of 6 -> all outputs at reset values next cycle; a new start of 2 beats then completes normally.
REQ-038 The bench SHALL check: fifo_valid pulsed in IDLE -> proto_err=1 and held until reset; no beat emitted.
